qv_nibble_mem_responder: RTL and testbench

Memory-side responder for the nibble-serial load/store interface of the tiny45 core. It captures a request when the core asserts address_ready, then runs a parallel 32-bit access on a simple backing-memory port. For loads it streams the result back one nibble per cycle, aligned to the core's 3-bit nibble counter. For stores it deserialises the core's store-data nibbles into a word before writing.

---
 rtl/qv_nibble_mem_responder_if.sv | 37 +++
 rtl/qv_nibble_mem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_qv_nibble_mem_responder.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qv_nibble_mem_responder_if.sv
// Nibble-serial core load/store bus plus the parallel 32-bit backing-memory port.
// master = core and memory side, slave = the responder.
interface qv_nibble_mem_responder_if #(
  parameter int ADDR_W = 28
);
  logic [2:0]        counter;
  logic              address_ready;
  logic [ADDR_W-1:0] addr_in;
  logic              is_store;
  logic [2:0]        mem_op;
  logic [3:0]        store_nibble;
  logic [3:0]        load_nibble;
  logic              load_data_ready;
  logic              busy;
  logic              misaligned;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output counter, address_ready, addr_in, is_store, mem_op, store_nibble,
           mem_rdata, mem_ready,
    input  load_nibble, load_data_ready, busy, misaligned, mem_addr,
           mem_read, mem_write, mem_wdata, mem_wmask
  );

  modport slave (
    input  counter, address_ready, addr_in, is_store, mem_op, store_nibble,
           mem_rdata, mem_ready,
    output load_nibble, load_data_ready, busy, misaligned, mem_addr,
           mem_read, mem_write, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/qv_nibble_mem_responder.sv
// Memory-side responder for the tiny45 nibble-serial load/store port: deserialises
// store data, runs one 32-bit memory access, and streams load data back per nibble.
module qv_nibble_mem_responder #(
  parameter int ADDR_W = 28
) (
  input  logic                        clk,
  input  logic                        rstn,
  qv_nibble_mem_responder_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    ALIGN   = 3'd4,
    STREAM  = 3'd5
  } state_t;

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [2:0]        op_r, op_s;
  logic [31:0]       sreg_r, sreg_s;
  logic [31:0]       lreg_r, lreg_s;
  logic              started_r, started_s;
  logic [2:0]        counter_nx_s;

  logic [3:0]        load_nibble_r, load_nibble_s;
  logic              load_data_ready_r, load_data_ready_s;
  logic              busy_r, busy_s;
  logic              misaligned_r, misaligned_s;
  logic              mem_read_r, mem_read_s;
  logic              mem_write_r, mem_write_s;
  logic [31:0]       mem_wdata_r, mem_wdata_s;
  logic [3:0]        mem_wmask_r, mem_wmask_s;

  // Reserved funct3 encodings are rejected exactly like misaligned accesses.
  function automatic logic op_rejected(input logic [2:0] op, input logic [1:0] off);
    logic bad;
    case (op)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [2:0] op,
                                              input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {off, 3'b000};
    case (op)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b100:  res = {24'h000000, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      3'b010:  res = rdata;
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_wdata(input logic [31:0] sreg, input logic [1:0] size);
    logic [31:0] res;
    case (size)
      2'b00:   res = {4{sreg[7:0]}};
      2'b01:   res = {2{sreg[15:0]}};
      2'b10:   res = sreg;
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_wmask(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] res;
    case (size)
      2'b00:   res = 4'b0001 << off;
      2'b01:   res = 4'b0011 << off;
      2'b10:   res = 4'b1111;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    op_s         = op_r;
    sreg_s       = sreg_r;
    lreg_s       = lreg_r;
    started_s    = started_r;
    misaligned_s = 1'b0;
    counter_nx_s = bus.counter + 3'd1;

    case (state_r)
      IDLE: begin
        if (bus.address_ready) begin
          addr_s = bus.addr_in;
          op_s   = bus.mem_op;
          sreg_s = 32'h00000000;
          if (op_rejected(bus.mem_op, bus.addr_in[1:0])) begin
            misaligned_s = 1'b1;
          end else if (bus.is_store) begin
            state_s = COLLECT;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      COLLECT: begin
        if ((bus.counter == 3'd0) || started_r) begin
          sreg_s[{bus.counter, 2'b00} +: 4] = bus.store_nibble;
          if (bus.counter == 3'd7) begin
            started_s = 1'b0;
            state_s   = WRITE;
          end else begin
            started_s = 1'b1;
          end
        end else begin
          started_s = 1'b0;
        end
      end
      WRITE: begin
        if (bus.mem_ready) begin
          state_s = IDLE;
        end else begin
          state_s = WRITE;
        end
      end
      READ: begin
        if (bus.mem_ready) begin
          lreg_s  = load_extend(bus.mem_rdata, op_r, addr_r[1:0]);
          state_s = (bus.counter == 3'd7) ? STREAM : ALIGN;
        end else begin
          state_s = READ;
        end
      end
      ALIGN: begin
        if (bus.counter == 3'd7) begin
          state_s = STREAM;
        end else begin
          state_s = ALIGN;
        end
      end
      STREAM: begin
        if (bus.counter == 3'd7) begin
          state_s = IDLE;
        end else begin
          state_s = STREAM;
        end
      end
      default: state_s = IDLE;
    endcase

    // Outputs are registered, so the nibble is picked for the counter value of the next cycle.
    busy_s            = (state_s != IDLE);
    mem_read_s        = (state_s == READ);
    mem_write_s       = (state_s == WRITE);
    mem_wdata_s       = (state_s == WRITE) ? store_wdata(sreg_s, op_r[1:0]) : 32'h00000000;
    mem_wmask_s       = (state_s == WRITE) ? store_wmask(op_r[1:0], addr_r[1:0]) : 4'b0000;
    load_data_ready_s = (state_s == STREAM);
    load_nibble_s     = (state_s == STREAM) ? lreg_s[{counter_nx_s, 2'b00} +: 4] : 4'h0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_r            <= '0;
      op_r              <= 3'b000;
      sreg_r            <= 32'h00000000;
      lreg_r            <= 32'h00000000;
      started_r         <= 1'b0;
      load_nibble_r     <= 4'h0;
      load_data_ready_r <= 1'b0;
      busy_r            <= 1'b0;
      misaligned_r      <= 1'b0;
      mem_read_r        <= 1'b0;
      mem_write_r       <= 1'b0;
      mem_wdata_r       <= 32'h00000000;
      mem_wmask_r       <= 4'b0000;
    end else begin
      addr_r            <= addr_s;
      op_r              <= op_s;
      sreg_r            <= sreg_s;
      lreg_r            <= lreg_s;
      started_r         <= started_s;
      load_nibble_r     <= load_nibble_s;
      load_data_ready_r <= load_data_ready_s;
      busy_r            <= busy_s;
      misaligned_r      <= misaligned_s;
      mem_read_r        <= mem_read_s;
      mem_write_r       <= mem_write_s;
      mem_wdata_r       <= mem_wdata_s;
      mem_wmask_r       <= mem_wmask_s;
    end
  end

  assign bus.load_nibble     = load_nibble_r;
  assign bus.load_data_ready = load_data_ready_r;
  assign bus.busy            = busy_r;
  assign bus.misaligned      = misaligned_r;
  assign bus.mem_addr        = {addr_r[ADDR_W-1:2], 2'b00};
  assign bus.mem_read        = mem_read_r;
  assign bus.mem_write       = mem_write_r;
  assign bus.mem_wdata       = mem_wdata_r;
  assign bus.mem_wmask       = mem_wmask_r;

endmodule

// File: tb/tb_qv_nibble_mem_responder.sv
// Self-checking bench for qv_nibble_mem_responder: scoreboard queues hold expected
// load words and memory writes, compared when the DUT streams or writes.
module tb_qv_nibble_mem_responder;
  localparam int ADDR_W = 28;

  logic clk = 1'b0;
  logic rstn;
  int checks = 0;
  int failures = 0;
  int mis_cnt = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int busy_cnt = 0;
  logic [31:0] store_word = 32'h00000000;
  logic [31:0] exp_q [$];
  logic [ADDR_W+35:0] wexp_q [$];

  qv_nibble_mem_responder_if #(.ADDR_W(ADDR_W)) bus ();
  qv_nibble_mem_responder #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;

  // Core nibble counter advances every cycle; store data follows it.
  initial begin
    bus.counter = 3'd0;
    bus.store_nibble = 4'h0;
    forever begin
      @(posedge clk); #1;
      bus.counter = bus.counter + 3'd1;
      bus.store_nibble = store_word[{bus.counter, 2'b00} +: 4];
    end
  end

  always @(negedge clk) begin
    if (bus.misaligned) mis_cnt <= mis_cnt + 1;
    if (bus.mem_read) rd_cnt <= rd_cnt + 1;
    if (bus.mem_write) wr_cnt <= wr_cnt + 1;
    if (bus.busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic issue(input logic [ADDR_W-1:0] a, input logic st, input logic [2:0] op);
    @(posedge clk); #1;
    bus.address_ready = 1'b1; bus.addr_in = a; bus.is_store = st; bus.mem_op = op;
    @(posedge clk); #1;
    bus.address_ready = 1'b0;
  endtask

  task automatic serve(input logic [31:0] d, input int lat, input logic at_c7, output logic done);
    int k = 0;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) begin
        k++;
        if ((!at_c7 && k == lat) || (at_c7 && bus.counter == 3'd7)) begin
          bus.mem_ready = 1'b1; bus.mem_rdata = d;
          @(posedge clk); #1;
          bus.mem_ready = 1'b0; bus.mem_rdata = 32'h00000000;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic collect_stream(input logic poke, output logic [31:0] word, output int n,
                                output logic order_ok, output int first_i);
    word = 32'h00000000; n = 0; order_ok = 1'b1; first_i = -1;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(negedge clk);
      bus.address_ready = 1'b0;
      if (bus.load_data_ready) begin
        if (first_i < 0) first_i = i;
        if (bus.counter != n[2:0]) order_ok = 1'b0;
        word[{bus.counter, 2'b00} +: 4] = bus.load_nibble;
        n++;
        if (poke && n == 2) begin
          bus.address_ready = 1'b1; bus.addr_in = 28'h0000500; bus.is_store = 1'b0;
          bus.mem_op = 3'b010;
        end
      end
    end
  endtask

  task automatic wait_write(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.mem_write;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.mem_read, bus.mem_write, bus.misaligned} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0000", {bus.busy, bus.mem_read, bus.mem_write, bus.misaligned});
    end
    checks++;
    if ({bus.load_data_ready, bus.load_nibble} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_load: got %b expected 00000", {bus.load_data_ready, bus.load_nibble});
    end
    checks++;
    if ({bus.mem_wdata, bus.mem_wmask} !== 36'h0) begin
      failures++;
      $display("FAIL reset_wdata: got %h/%b expected 0/0000", bus.mem_wdata, bus.mem_wmask);
    end
    checks++;
    if (bus.mem_addr !== 28'h0) begin
      failures++;
      $display("FAIL reset_addr: got %h expected 0", bus.mem_addr);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_lw();
    logic [31:0] word, exp;
    int n, fi, rd0;
    logic ord, done;
    exp_q.push_back(32'hDEADBEEF);
    rd0 = rd_cnt;
    issue(28'h0000100, 1'b0, 3'b010);
    serve(32'hDEADBEEF, 3, 1'b0, done);
    checks++;
    if (!done || (rd_cnt - rd0) != 3) begin
      failures++;
      $display("FAIL lw_read_hold: got done=%0b cycles=%0d expected 1/3", done, rd_cnt - rd0);
    end
    checks++;
    if (bus.mem_addr !== 28'h0000100) begin
      failures++;
      $display("FAIL lw_addr: got %h expected 0000100", bus.mem_addr);
    end
    collect_stream(1'b0, word, n, ord, fi);
    exp = exp_q.pop_front();
    checks++;
    if (word !== exp || n != 8 || !ord) begin
      failures++;
      $display("FAIL lw_stream: got %h n=%0d order=%0b expected %h n=8 order=1", word, n, ord, exp);
    end
    @(negedge clk);
    checks++;
    if ({bus.load_data_ready, bus.load_nibble, bus.busy} !== 6'b000000) begin
      failures++;
      $display("FAIL lw_after: got %b expected 000000", {bus.load_data_ready, bus.load_nibble, bus.busy});
    end
  endtask

  task automatic test_lb_lbu();
    logic [2:0] ops [2] = '{3'b000, 3'b100};
    logic [31:0] exps [2] = '{32'hFFFFFF80, 32'h00000080};
    logic [31:0] word, exp;
    int n, fi;
    logic ord, done;
    for (int c = 0; c < 2; c++) begin
      exp_q.push_back(exps[c]);
      issue(28'h0000103, 1'b0, ops[c]);
      serve(32'h80123456, 1, 1'b0, done);
      collect_stream(1'b0, word, n, ord, fi);
      exp = exp_q.pop_front();
      checks++;
      if (!done || word !== exp || n != 8 || !ord) begin
        failures++;
        $display("FAIL lb_case%0d: got %h n=%0d done=%0b expected %h n=8", c, word, n, done, exp);
      end
    end
  endtask

  task automatic test_sh();
    logic [ADDR_W+35:0] w;
    logic seen;
    store_word = 32'h0000ABCD;
    wexp_q.push_back({28'h0000200, 32'hABCDABCD, 4'b1100});
    issue(28'h0000202, 1'b1, 3'b001);
    wait_write(seen);
    w = wexp_q.pop_front();
    checks++;
    if (!seen || {bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== w) begin
      failures++;
      $display("FAIL sh_write: got seen=%0b %h %h %b expected %h", seen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, w);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_write !== 1'b1 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL sh_hold: got write=%b busy=%b expected 1/1", bus.mem_write, bus.busy);
    end
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.mem_write !== 1'b0) begin
      failures++;
      $display("FAIL sh_done: got busy=%b write=%b expected 0/0", bus.busy, bus.mem_write);
    end
  endtask

  task automatic test_misaligned();
    logic [ADDR_W-1:0] addrs [3] = '{28'h0000101, 28'h0000003, 28'h0000010};
    logic sts [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0] ops [3] = '{3'b010, 3'b001, 3'b011};
    int m0, r0, w0, b0;
    for (int c = 0; c < 3; c++) begin
      m0 = mis_cnt; r0 = rd_cnt; w0 = wr_cnt; b0 = busy_cnt;
      issue(addrs[c], sts[c], ops[c]);
      repeat (6) @(negedge clk);
      checks++;
      if (mis_cnt - m0 != 1) begin
        failures++;
        $display("FAIL mis%0d_pulse: got %0d pulses expected 1", c, mis_cnt - m0);
      end
      checks++;
      if (rd_cnt - r0 != 0) begin
        failures++;
        $display("FAIL mis%0d_read: got %0d read cycles expected 0", c, rd_cnt - r0);
      end
      checks++;
      if (wr_cnt - w0 != 0) begin
        failures++;
        $display("FAIL mis%0d_write: got %0d write cycles expected 0", c, wr_cnt - w0);
      end
      checks++;
      if (busy_cnt - b0 != 0) begin
        failures++;
        $display("FAIL mis%0d_busy: got %0d busy cycles expected 0", c, busy_cnt - b0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] word, exp;
    int n, fi;
    logic ord, done;
    issue(28'h0000300, 1'b0, 3'b010);
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got mem_read=%b expected 1", bus.mem_read);
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.mem_read !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_post: got read=%b busy=%b expected 0/0", bus.mem_read, bus.busy);
    end
    exp_q.push_back(32'h12345678);
    issue(28'h0000304, 1'b0, 3'b010);
    serve(32'h12345678, 2, 1'b0, done);
    collect_stream(1'b0, word, n, ord, fi);
    exp = exp_q.pop_front();
    checks++;
    if (!done || word !== exp || n != 8 || !ord) begin
      failures++;
      $display("FAIL rst_mid_fresh: got %h n=%0d done=%0b expected %h n=8", word, n, done, exp);
    end
  endtask

  task automatic test_stream_ignore();
    logic [31:0] word, exp;
    int n, fi, r0, b0;
    logic ord, done;
    exp_q.push_back(32'hCAFEF00D);
    issue(28'h0000400, 1'b0, 3'b010);
    serve(32'hCAFEF00D, 0, 1'b1, done);
    r0 = rd_cnt;
    collect_stream(1'b1, word, n, ord, fi);
    exp = exp_q.pop_front();
    checks++;
    if (!done || word !== exp || n != 8 || !ord) begin
      failures++;
      $display("FAIL c7_stream: got %h n=%0d done=%0b expected %h n=8", word, n, done, exp);
    end
    checks++;
    if (fi != 0) begin
      failures++;
      $display("FAIL c7_start: got first nibble at cycle %0d expected 0", fi);
    end
    @(negedge clk);
    b0 = busy_cnt;
    repeat (5) @(negedge clk);
    checks++;
    if (rd_cnt - r0 != 0 || busy_cnt - b0 != 0) begin
      failures++;
      $display("FAIL ignore_req: got read=%0d busy=%0d cycles expected 0/0", rd_cnt - r0, busy_cnt - b0);
    end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W+35:0] w;
    logic [31:0] word, exp;
    int n, fi;
    logic seen, ord, done;
    store_word = 32'h11223344;
    wexp_q.push_back({28'h0000600, 32'h11223344, 4'b1111});
    issue(28'h0000600, 1'b1, 3'b010);
    wait_write(seen);
    w = wexp_q.pop_front();
    checks++;
    if (!seen || {bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== w) begin
      failures++;
      $display("FAIL b2b_sw: got seen=%0b %h %h %b expected %h", seen, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, w);
    end
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    exp_q.push_back(32'h0BADC0DE);
    bus.address_ready = 1'b1; bus.addr_in = 28'h0000604; bus.is_store = 1'b0; bus.mem_op = 3'b010;
    @(posedge clk); #1;
    bus.address_ready = 1'b0;
    serve(32'h0BADC0DE, 1, 1'b0, done);
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL b2b_accept: got done=%0b expected 1", done);
    end
    collect_stream(1'b0, word, n, ord, fi);
    exp = exp_q.pop_front();
    checks++;
    if (word !== exp || n != 8 || !ord) begin
      failures++;
      $display("FAIL b2b_lw: got %h n=%0d expected %h n=8", word, n, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.address_ready = 1'b0;
    bus.addr_in = 28'h0;
    bus.is_store = 1'b0;
    bus.mem_op = 3'b000;
    bus.mem_rdata = 32'h00000000;
    bus.mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_reset_mid();
    test_stream_ignore();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
